// File: rtl/mc_datapath_if.sv
// Instruction-accept handshake and memory bus of the multi-cycle datapath.
interface mc_datapath_if #(
    parameter int XLEN = 32
);
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;

    modport master (
        output instr_valid, instr, mem_rdata, mem_ready,
        input  instr_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  instr_valid, instr, mem_rdata, mem_ready,
        output instr_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mc_datapath.sv
// Multi-cycle datapath: IDLE/EXEC/MEM/WB, one instruction in flight.
// Define MC_DATAPATH_UJ_IMM_EN to add U (011) and J (100) immediates.
module mc_datapath #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    mc_datapath_if.slave    bus,
    input  logic            reg_write,
    input  logic            mem_write,
    input  logic            alu_src,
    input  logic            result_src,
    input  logic [2:0]      imm_src,
    input  logic [2:0]      alu_control,
    output logic            done,
    output logic            zero,
    output logic [XLEN-1:0] immediate
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

    state_t state;
    state_t state_nx;

    logic [31:0]     instr_q;
    logic            rw_q;
    logic            mw_q;
    logic            asrc_q;
    logic            rsrc_q;
    logic [2:0]      aluc_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] mrd_q;
    logic [XLEN-1:0] regs [NREGS];

    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_y;
    logic [XLEN-1:0] wb_data;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;
    logic            accept;
    logic            unused;

    assign accept = bus.instr_valid && bus.instr_ready;

    // Opcode/funct bits are decoded outside; only fields are consumed here.
    assign unused = ^instr_q;

    assign rs1 = instr_q[15 +: AW];
    assign rs2 = instr_q[20 +: AW];
    assign rd  = instr_q[7 +: AW];

    assign rs1_val = (rs1 == '0) ? '0 : regs[rs1];
    assign rs2_val = (rs2 == '0) ? '0 : regs[rs2];
    assign alu_b   = asrc_q ? immediate : rs2_val;
    assign wb_data = rsrc_q ? mrd_q : alu_q;

    always_comb begin
        imm32 = '0;
        unique case (1'b1)
            (imm_src == 3'b000):
                imm32 = {{20{bus.instr[31]}}, bus.instr[31:20]};
            (imm_src == 3'b001):
                imm32 = {{20{bus.instr[31]}}, bus.instr[31:25],
                         bus.instr[11:7]};
            (imm_src == 3'b010):
                imm32 = {{19{bus.instr[31]}}, bus.instr[31],
                         bus.instr[7], bus.instr[30:25],
                         bus.instr[11:8], 1'b0};
`ifdef MC_DATAPATH_UJ_IMM_EN
            (imm_src == 3'b011):
                imm32 = {bus.instr[31:12], 12'b0};
            (imm_src == 3'b100):
                imm32 = {{11{bus.instr[31]}}, bus.instr[31],
                         bus.instr[19:12], bus.instr[20],
                         bus.instr[30:21], 1'b0};
`endif
            default:
                imm32 = '0;
        endcase
    end

    assign imm_ext = XLEN'($signed(imm32));

    always_comb begin
        alu_y = '0;
        case (aluc_q)
            3'b000:  alu_y = rs1_val + alu_b;
            3'b001:  alu_y = rs1_val - alu_b;
            3'b010:  alu_y = rs1_val & alu_b;
            3'b011:  alu_y = rs1_val | alu_b;
            3'b101:  alu_y = {{(XLEN-1){1'b0}},
                              $signed(rs1_val) < $signed(alu_b)};
            default: alu_y = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = EXEC;
            EXEC: state_nx = (rsrc_q || mw_q) ? MEM : WB;
            MEM:  if (bus.mem_ready) state_nx = WB;
            WB:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Gating with rst makes the handshake outputs drop the moment reset asserts.
    always_comb begin
        bus.instr_ready = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        done            = 1'b0;
        if (rst) begin
            bus.instr_ready = (state == IDLE);
            bus.mem_req     = (state == MEM);
            bus.mem_we      = (state == MEM) && mw_q;
            done            = (state == WB);
        end
    end

    assign bus.mem_addr  = alu_q;
    assign bus.mem_wdata = rs2_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q   <= '0;
            rw_q      <= 1'b0;
            mw_q      <= 1'b0;
            asrc_q    <= 1'b0;
            rsrc_q    <= 1'b0;
            aluc_q    <= '0;
            immediate <= '0;
            alu_q     <= '0;
            zero      <= 1'b1;
            mrd_q     <= '0;
        end else begin
            if (state == IDLE && accept) begin
                instr_q   <= bus.instr;
                rw_q      <= reg_write;
                mw_q      <= mem_write;
                asrc_q    <= alu_src;
                rsrc_q    <= result_src;
                aluc_q    <= alu_control;
                immediate <= imm_ext;
            end
            if (state == EXEC) begin
                alu_q <= alu_y;
                zero  <= (alu_y == '0);
            end
            if (state == MEM && bus.mem_ready) begin
                mrd_q <= bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state == WB && rw_q && rd != '0) begin
            regs[rd] <= wb_data;
        end
    end
endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: directed instructions, queued
// expectations, and a negedge monitor checking memory and retire.
module tb_mc_datapath;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            reg_write;
    logic            mem_write;
    logic            alu_src;
    logic            result_src;
    logic [2:0]      imm_src;
    logic [2:0]      alu_control;
    logic            done;
    logic            zero;
    logic [XLEN-1:0] immediate;

    always #5 clk = ~clk;

    mc_datapath_if #(.XLEN(XLEN)) bus ();

    mc_datapath #(.XLEN(XLEN), .NREGS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .result_src (result_src),
        .imm_src    (imm_src),
        .alu_control(alu_control),
        .done       (done),
        .zero       (zero),
        .immediate  (immediate)
    );

    typedef struct {
        logic            zero;
        logic [XLEN-1:0] imm;
        bit              has_mem;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic            we;
        int              lat;
        int              mcyc;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            e;
    int              total = 0;
    int              bad = 0;
    int              mem_wait = 0;
    logic [XLEN-1:0] rdata_v = '0;
    bit              busy = 0;
    bit              ready_pend = 0;
    int              cyc = 0;
    int              mcnt = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Memory model: holds mem_ready low for mem_wait cycles of a request.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_req) begin
                if (wcnt < mem_wait) begin
                    bus.mem_ready = 1'b0;
                    wcnt++;
                end else begin
                    bus.mem_ready = 1'b1;
                end
            end else begin
                bus.mem_ready = 1'b0;
                wcnt = 0;
            end
            bus.mem_rdata = rdata_v;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            busy = 0;
            ready_pend = 0;
            mcnt = 0;
        end else begin
            if (ready_pend) begin
                check("ready_again", bus.instr_ready, 1);
                ready_pend = 0;
            end
            if (busy) cyc++;
            if (bus.mem_req) begin
                if (exp_q.size() == 0) begin
                    check("spurious_mem", bus.mem_req, 0);
                end else begin
                    mcnt++;
                    check("mem_expected", bus.mem_req, exp_q[0].has_mem);
                    check("mem_addr", bus.mem_addr, exp_q[0].addr);
                    check("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
                    check("mem_we", bus.mem_we, exp_q[0].we);
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", done, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("zero", zero, e.zero);
                    check("immediate", immediate, e.imm);
                    check("latency", cyc, e.lat);
                    check("mem_cycles", mcnt, e.mcyc);
                    check("ready_in_wb", bus.instr_ready, 0);
                    ready_pend = 1;
                    busy = 0;
                    mcnt = 0;
                end
            end
            if (bus.instr_valid && bus.instr_ready) begin
                busy = 1;
                cyc = 0;
                mcnt = 0;
            end
        end
    end

    task automatic offer(input logic [31:0] in, input logic rw,
                         input logic mw, input logic as, input logic rs,
                         input logic [2:0] is, input logic [2:0] ac);
        @(posedge clk);
        #1;
        bus.instr = in;
        reg_write = rw;
        mem_write = mw;
        alu_src = as;
        result_src = rs;
        imm_src = is;
        alu_control = ac;
        bus.instr_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.instr_ready) break;
        end
        if (!bus.instr_ready) check("accept_timeout", bus.instr_ready, 1);
        @(posedge clk);
        #1;
        // Scrambled controls and a stray offer while busy must be ignored.
        bus.instr = ~in;
        reg_write = ~rw;
        mem_write = ~mw;
        alu_src = ~as;
        result_src = ~rs;
        imm_src = ~is;
        alu_control = ~ac;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic issue(input logic [31:0] in, input logic rw,
                         input logic mw, input logic as, input logic rs,
                         input logic [2:0] is, input logic [2:0] ac,
                         input int wt, input logic [XLEN-1:0] rd,
                         input logic ez, input logic [XLEN-1:0] eimm,
                         input bit hm, input logic [XLEN-1:0] ea,
                         input logic [XLEN-1:0] ew, input logic ewe);
        exp_t x;
        x.zero = ez;
        x.imm = eimm;
        x.has_mem = hm;
        x.addr = ea;
        x.wdata = ew;
        x.we = ewe;
        x.mcyc = hm ? wt + 1 : 0;
        x.lat = hm ? 3 + wt : 2;
        mem_wait = wt;
        rdata_v = rd;
        exp_q.push_back(x);
        offer(in, rw, mw, as, rs, is, ac);
        for (int n = 0; n < 200; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            check("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        logic [XLEN-1:0] j_imm;
        logic [XLEN-1:0] u_imm;
`ifdef MC_DATAPATH_UJ_IMM_EN
        j_imm = 32'hFFF0_0000;
        u_imm = 32'h1234_5000;
`else
        j_imm = '0;
        u_imm = '0;
`endif
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        alu_src = 1'b0;
        result_src = 1'b0;
        imm_src = '0;
        alu_control = '0;

        repeat (2) @(negedge clk);
        check("rst_ready", bus.instr_ready, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_done", done, 0);
        check("rst_zero", zero, 1);
        check("rst_imm", immediate, 0);
        rst = 1'b1;
        #1;
        check("ready_after_rst", bus.instr_ready, 1);

        // instr rw mw as rs is ac wait rdata | zero imm mem addr wdata we
        issue(32'h00500093, 1, 0, 1, 0, 0, 0, 0, 0,
              0, 5, 0, 0, 0, 0);
        issue(32'h40108133, 1, 0, 0, 0, 0, 1, 0, 0,
              1, 32'h401, 0, 0, 0, 0);
        issue(32'h00102423, 0, 1, 1, 0, 1, 0, 3, 0,
              0, 8, 1, 8, 5, 1);
        issue(32'h00802183, 1, 0, 1, 1, 0, 0, 0, 32'hDEADBEEF,
              0, 8, 1, 8, 0, 0);
        issue(32'h00302623, 0, 1, 1, 0, 1, 0, 1, 0,
              0, 12, 1, 12, 32'hDEADBEEF, 1);
        issue(32'h00700013, 1, 0, 1, 0, 0, 0, 0, 0,
              0, 7, 0, 0, 0, 0);
        issue(32'h00002823, 0, 1, 1, 0, 1, 0, 0, 0,
              0, 16, 1, 16, 0, 1);
        issue(32'hFFF00313, 1, 0, 1, 0, 0, 0, 0, 0,
              0, 32'hFFFFFFFF, 0, 0, 0, 0);
        issue(32'h001323B3, 1, 0, 0, 0, 0, 5, 0, 0,
              0, 1, 0, 0, 0, 0);
        issue(32'h0073A023, 0, 1, 1, 0, 1, 0, 0, 0,
              0, 0, 1, 1, 1, 1);
        issue(32'h00137433, 1, 0, 0, 0, 0, 2, 0, 0,
              0, 1, 0, 0, 0, 0);
        issue(32'h00802A23, 0, 1, 1, 0, 1, 0, 2, 0,
              0, 20, 1, 20, 5, 1);
        issue(32'h0000E033, 1, 0, 0, 0, 0, 3, 0, 0,
              0, 0, 0, 0, 0, 0);
        issue(32'h00008033, 1, 0, 0, 0, 0, 6, 0, 0,
              1, 0, 0, 0, 0, 0);
        issue(32'h80000063, 0, 0, 1, 0, 2, 0, 0, 0,
              0, 32'hFFFFF000, 0, 0, 0, 0);
        issue(32'h8000006F, 0, 0, 0, 0, 4, 0, 0, 0,
              1, j_imm, 0, 0, 0, 0);
        issue(32'h12345037, 0, 0, 1, 0, 3, 0, 0, 0,
              0, u_imm, 0, 0, 0, 0);
        issue(32'hFFFFFFFF, 0, 0, 1, 0, 7, 0, 0, 0,
              1, 0, 0, 0, 0, 0);

        // Reset pulse while a store is parked in MEM.
        begin
            exp_t x;
            x.zero = 0;
            x.imm = 4;
            x.has_mem = 1;
            x.addr = 9;
            x.wdata = 5;
            x.we = 1;
            x.mcyc = 0;
            x.lat = 0;
            mem_wait = 1000;
            exp_q.push_back(x);
        end
        offer(32'h0010A223, 0, 1, 1, 0, 1, 0);
        for (int n = 0; n < 20; n++) begin
            if (bus.mem_req) break;
            @(negedge clk);
        end
        check("mem_req_before_rst", bus.mem_req, 1);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midmem_mem_req", bus.mem_req, 0);
        check("midmem_mem_we", bus.mem_we, 0);
        check("midmem_ready", bus.instr_ready, 0);
        check("midmem_done", done, 0);
        check("midmem_zero", zero, 1);
        check("midmem_imm", immediate, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_after_rst2", bus.instr_ready, 1);
        issue(32'h0010A223, 0, 1, 1, 0, 1, 0, 0, 0,
              0, 4, 1, 4, 0, 1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, the datapath/register width (legal values 32 and 64).
REQ-002 The module SHALL have parameter NREGS, default 32, the register count (power of 2, 2..32); register index = instr field modulo NREGS.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, the reset: asynchronous, active-low.
REQ-005 The module SHALL have the instruction-accept ports: instr_valid in 1 (offer); instr_ready out 1 (accept); instr in 32 (instruction word).
REQ-006 The module SHALL have the per-instruction control inputs: reg_write in 1; mem_write in 1; alu_src in 1 (1 = immediate); result_src in 1 (1 = memory data); imm_src in 3; alu_control in 3.
REQ-007 The module SHALL have the memory ports: mem_req out 1; mem_we out 1; mem_addr out XLEN; mem_wdata out XLEN; mem_rdata in XLEN; mem_ready in 1.
REQ-008 The module SHALL have the status outputs: done out 1 (retire pulse); zero out 1 (registered ALU result == 0); immediate out XLEN (latched immediate).

Function
REQ-009 The FSM SHALL have states IDLE, EXEC, MEM, WB; instr_ready = 1 only in IDLE.
REQ-010 On instr_valid && instr_ready, the FSM SHALL latch instr and all control inputs, then IDLE -> EXEC.
REQ-011 EXEC SHALL read rs1 = instr[19:15] and rs2 = instr[24:20], compute the ALU result into an internal register, and update zero.
REQ-012 From EXEC, the FSM SHALL go to MEM if result_src or mem_write is latched, else to WB.
REQ-013 In MEM, mem_req SHALL be 1; mem_addr = ALU result; mem_we = latched mem_write; mem_wdata = rs2 value; all held stable until mem_ready.
REQ-014 The FSM SHALL leave MEM for WB on the first cycle with mem_ready = 1, latching mem_rdata into a read register; waits are unbounded.
REQ-015 In WB, if reg_write is latched and rd = instr[11:7] != 0, the block SHALL write rd (mem read register if result_src, else ALU result); done = 1 for that cycle; next state IDLE.
REQ-016 The non-memory latency SHALL be accept edge T, EXEC T+1, done at T+2, instr_ready again at T+3.
REQ-017 Register 0 SHALL always read 0; writes to it SHALL be ignored.
REQ-018 The ALU SHALL implement: 000 add, 001 sub, 010 and, 011 or, 101 signed set-less-than (result 1 or 0), others 0; arithmetic wraps modulo 2^XLEN, no flags besides zero.
REQ-019 The immediate SHALL be sign-extended to XLEN: imm_src 000 I {instr[31:20]}; 001 S {instr[31:25],instr[11:7]}; 010 B {instr[31],instr[7],instr[30:25],instr[11:8],0}.
REQ-020 An instr_valid not accepted outside IDLE SHALL have no effect; any change to the control inputs after accept SHALL be ignored.
REQ-021 A read of rs1/rs2 SHALL return the value written by the prior instruction's WB (no hazard: at most one instruction is in flight).

Reset
REQ-022 While rst = 0, the block SHALL force state = IDLE, all registers (regfile, ALU, read, latched instr/ctrl) = 0, instr_ready = 0, mem_req = 0, mem_we = 0, done = 0, zero = 1, immediate = 0.
REQ-023 A reset assertion mid-MEM SHALL drop mem_req immediately (asynchronously); no register write SHALL occur.
REQ-024 The first edge after rst deassertion SHALL see instr_ready = 1.

Configuration
REQ-025 With macro MC_DATAPATH_UJ_IMM_EN defined, the block SHALL support imm_src 011 U {instr[31:12],12'b0} and 100 J {instr[31],instr[19:12],instr[20],instr[30:21],0}, each sign-extended.
REQ-026 With MC_DATAPATH_UJ_IMM_EN undefined, imm_src 011 and 100 SHALL give immediate = 0, exactly as every other unlisted code does.

Verification
REQ-027 The bench SHALL cover addi x1,x0,5 (instr 0x00500093, alu_src=1, reg_write=1, imm_src 000, alu_control 000) -> done at accept+2, x1 = 5, zero = 0.
REQ-028 The bench SHALL cover sub x2,x1,x1 after REQ-027 -> x2 = 0, zero = 1.
REQ-029 The bench SHALL cover sw x1,8(x0) with mem_ready held 0 for 3 cycles -> mem_req for 4 cycles, mem_addr = 8, mem_wdata = 5, mem_we = 1, stable throughout; done 1 cycle after mem_ready.
REQ-030 The bench SHALL cover lw x3,8(x0) with mem_rdata = 0xDEADBEEF -> x3 = 0xDEADBEEF (XLEN = 64: 0xFFFFFFFFDEADBEEF after sign handling by the memory model; the datapath stores as given).
REQ-031 The bench SHALL cover addi x0,x0,7, then a read of x0 -> 0; imm 0xFFF -> immediate all ones.
REQ-032 The bench SHALL cover an rst pulse while in MEM -> mem_req = 0 at once, all registers 0; with the macro defined, a J-immediate of instr 0x8000006F -> immediate 0xFFF00000.
